// File: rtl/bayer_cross_window.sv
// Bayer cross-neighbourhood window generator.
// Takes raster-order Bayer pixels and produces, for every interior centre
// pixel, the 9-tap cross (two pixels up/down/left/right of the centre).
// It uses four cascaded line buffers, a horizontal shift chain on the
// row-2 line, and short column delays on the vertical taps.
// The window is registered, so it appears one clock after the pixel that
// completes it.
module bayer_cross_window #(
  parameter int pixelBitWidth = 12,
  parameter int maxLineWidth  = 1024,
  parameter int addrWidth     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [pixelBitWidth-1:0] pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  input  logic [addrWidth:0]       line_width,
  output logic [pixelBitWidth-1:0] p_m2_p0,
  output logic [pixelBitWidth-1:0] p_m1_p0,
  output logic [pixelBitWidth-1:0] p_p0_m2,
  output logic [pixelBitWidth-1:0] p_p0_m1,
  output logic [pixelBitWidth-1:0] p_p0_p0,
  output logic [pixelBitWidth-1:0] p_p0_p1,
  output logic [pixelBitWidth-1:0] p_p0_p2,
  output logic [pixelBitWidth-1:0] p_p1_p0,
  output logic [pixelBitWidth-1:0] p_p2_p0,
  output logic                     win_valid,
  output logic [15:0]              win_row,
  output logic [addrWidth-1:0]     win_col,
  output logic [1:0]               win_phase,
  output logic                     width_err
);

  localparam int PW = pixelBitWidth;
  localparam logic [addrWidth:0]   MIN_WIDTH = (addrWidth+1)'(5);
  localparam logic [addrWidth:0]   MAX_WIDTH = (addrWidth+1)'(maxLineWidth);
  localparam logic [addrWidth:0]   WIDTH_ONE = (addrWidth+1)'(1);
  localparam logic [addrWidth-1:0] COL_ONE   = addrWidth'(1);
  localparam logic [addrWidth-1:0] COL_TWO   = addrWidth'(2);
  localparam logic [addrWidth-1:0] COL_FOUR  = addrWidth'(4);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state_r, state_nxt_s;
  logic [addrWidth:0]   width_r;
  logic [addrWidth-1:0] col_r;
  logic [15:0]          row_r;

  logic                 sof_acc_s, width_ok_s, proc_s, last_col_s, win_fire_s;
  logic [addrWidth:0]   eff_width_s;
  logic [addrWidth-1:0] pos_col_s, cen_col_s;
  logic [15:0]          pos_row_s, cen_row_s;

  // Line buffers (not reset) and their same-cycle read ports.
  logic [PW-1:0] lb1_r [0:maxLineWidth-1];
  logic [PW-1:0] lb2_r [0:maxLineWidth-1];
  logic [PW-1:0] lb3_r [0:maxLineWidth-1];
  logic [PW-1:0] lb4_r [0:maxLineWidth-1];
  logic [PW-1:0] lb1_rd_s, lb2_rd_s, lb3_rd_s, lb4_rd_s;

  // Horizontal chain on row-2 (the live LB2 read is the newest tap) and
  // two-deep column delays on rows -4, -3, -1 and the live row.
  logic [PW-1:0] h_r  [4];
  logic [PW-1:0] v4_r [2];
  logic [PW-1:0] v3_r [2];
  logic [PW-1:0] v1_r [2];
  logic [PW-1:0] v0_r [2];

  // A sof pixel is itself position (0,0), so position and width come from the sof path.
  assign sof_acc_s   = pix_valid & sof;
  assign width_ok_s  = (line_width >= MIN_WIDTH) && (line_width <= MAX_WIDTH);
  assign proc_s      = pix_valid & ((sof & width_ok_s) | (~sof & (state_r == ACTIVE)));
  assign pos_row_s   = sof_acc_s ? 16'd0 : row_r;
  assign pos_col_s   = sof_acc_s ? '0 : col_r;
  assign eff_width_s = sof_acc_s ? line_width : width_r;
  assign last_col_s  = ({1'b0, pos_col_s} == (eff_width_s - WIDTH_ONE));
  assign win_fire_s  = proc_s && (pos_row_s >= 16'd4) && (pos_col_s >= COL_FOUR);
  assign cen_row_s   = pos_row_s - 16'd2;
  assign cen_col_s   = pos_col_s - COL_TWO;

  assign lb1_rd_s = lb1_r[pos_col_s];
  assign lb2_rd_s = lb2_r[pos_col_s];
  assign lb3_rd_s = lb3_r[pos_col_s];
  assign lb4_rd_s = lb4_r[pos_col_s];

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next state: any accepted sof decides between restarting and parking in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (sof_acc_s) begin
      if (width_ok_s) state_nxt_s = ACTIVE;
      else            state_nxt_s = IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Raster position tracking: column wraps at width-1, row saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_r <= '0;
      col_r   <= '0;
      row_r   <= 16'd0;
    end else if (proc_s) begin
      width_r <= eff_width_s;
      if (last_col_s) begin
        col_r <= '0;
        row_r <= (pos_row_s == 16'hFFFF) ? pos_row_s : pos_row_s + 16'd1;
      end else begin
        col_r <= pos_col_s + COL_ONE;
        row_r <= pos_row_s;
      end
    end
  end

  // Sticky width error: follows the legality of the most recent sof.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           width_err <= 1'b0;
    else if (sof_acc_s) width_err <= ~width_ok_s;
  end

  // Cascaded line buffers: read column then write, pushing each row one buffer deeper.
  always_ff @(posedge clk) begin
    if (proc_s) begin
      lb1_r[pos_col_s] <= pix_in;
      lb2_r[pos_col_s] <= lb1_rd_s;
      lb3_r[pos_col_s] <= lb2_rd_s;
      lb4_r[pos_col_s] <= lb3_rd_s;
    end
  end

  // Tap shift registers; advance only on processed pixels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) h_r[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        v4_r[i] <= '0;
        v3_r[i] <= '0;
        v1_r[i] <= '0;
        v0_r[i] <= '0;
      end
    end else if (proc_s) begin
      h_r[0]  <= lb2_rd_s;
      h_r[1]  <= h_r[0];
      h_r[2]  <= h_r[1];
      h_r[3]  <= h_r[2];
      v4_r[0] <= lb4_rd_s;
      v4_r[1] <= v4_r[0];
      v3_r[0] <= lb3_rd_s;
      v3_r[1] <= v3_r[0];
      v1_r[0] <= lb1_rd_s;
      v1_r[1] <= v1_r[0];
      v0_r[0] <= pix_in;
      v0_r[1] <= v0_r[0];
    end
  end

  // Window register: loads only for interior centres, otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
      p_m2_p0   <= '0;
      p_m1_p0   <= '0;
      p_p0_m2   <= '0;
      p_p0_m1   <= '0;
      p_p0_p0   <= '0;
      p_p0_p1   <= '0;
      p_p0_p2   <= '0;
      p_p1_p0   <= '0;
      p_p2_p0   <= '0;
      win_row   <= 16'd0;
      win_col   <= '0;
      win_phase <= 2'b00;
    end else begin
      win_valid <= win_fire_s;
      if (win_fire_s) begin
        p_m2_p0   <= v4_r[1];
        p_m1_p0   <= v3_r[1];
        p_p0_m2   <= h_r[3];
        p_p0_m1   <= h_r[2];
        p_p0_p0   <= h_r[1];
        p_p0_p1   <= h_r[0];
        p_p0_p2   <= lb2_rd_s;
        p_p1_p0   <= v1_r[1];
        p_p2_p0   <= v0_r[1];
        win_row   <= cen_row_s;
        win_col   <= cen_col_s;
        win_phase <= {cen_row_s[0], cen_col_s[0]};
      end
    end
  end

endmodule
